l2_arbiter: RTL and testbench

- Arbitrates the shared unified L2 cache between the L1 instruction-cache miss path (I side) and the L1 data-cache miss/writeback path (D side).
- Sits between both L1 controllers and the single L2 request port.
- Holds a grant for the full L2 transaction and alternates ties round-robin.
- Produces per-side wait flags; d_wait feeds the hazard unit's CacheWait, i_wait feeds fetch stall.
- Includes a transaction watchdog.

---
 rtl/l2_arbiter_pkg.sv | 17 +
 rtl/l2_arbiter_rr_pick2.sv | 24 ++
 rtl/l2_arbiter.sv | 110 +++++++++++
 tb/tb_l2_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arbiter_pkg.sv
// Shared definitions for the L1-to-L2 arbiter: state encoding, side ids and
// the default line/address widths used by the L1 and L2 controllers.
package l2_arbiter_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 128;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } arbStateT;

endpackage

// File: rtl/l2_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins, and a tie goes to the
// side that did not own the previous grant.
module rr_pick2
    import l2_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_side
);

    always_comb begin
        grant_valid = i_req | d_req;
        if (i_req && d_req) begin
            grant_side = ~last_grant;
        end else if (d_req) begin
            grant_side = SIDE_D;
        end else begin
            grant_side = SIDE_I;
        end
    end

endmodule

// File: rtl/l2_arbiter.sv
// Arbiter between the I-cache and D-cache miss paths for the single L2 port.
// Grants are held for a whole L2 transaction and guarded by a watchdog.
module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              i_ready,
    output logic              d_ready,
    output logic [LINE_W-1:0] i_rdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              i_wait,
    output logic              d_wait,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic              l2_ready,
    input  logic [LINE_W-1:0] l2_rdata,
    output logic              err,
    output arbStateT          dbgState
);

    // Handshake: a requester raises x_req and holds it (with stable address and
    // data) until the single-cycle x_ready pulse; L2 sees l2_req held for the
    // whole grant and answers with a single-cycle l2_ready pulse.

    arbStateT   state;
    logic       lastGrant;
    logic [7:0] cnt;
    logic       pickValid;
    logic       pickSide;
    logic       ownerI;
    logic       ownerD;
    logic       busy;
    logic       timeout;
    logic       done;

    rr_pick2 u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
        .last_grant (lastGrant),
        .grant_valid(pickValid),
        .grant_side (pickSide)
    );

    always_comb begin
        ownerI  = (state == GNT_I);
        ownerD  = (state == GNT_D);
        busy    = ownerI | ownerD;
        // A real completion on the deadline cycle wins over the abort.
        timeout = busy && !l2_ready && (cnt == 8'(TIMEOUT));
        done    = busy && (l2_ready || timeout) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lastGrant <= SIDE_I;
            cnt       <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        state <= (pickSide == SIDE_D) ? GNT_D : GNT_I;
                        cnt   <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (done) begin
                        state     <= IDLE;
                        lastGrant <= ownerD ? SIDE_D : SIDE_I;
                        if (timeout) begin
                            err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        l2_req   = busy;
        l2_we    = ownerD & d_we;
        l2_addr  = ownerD ? d_addr : (ownerI ? i_addr : '0);
        l2_wdata = ownerD ? d_wdata : '0;
        i_ready  = ownerI & done;
        d_ready  = ownerD & done;
        i_rdata  = (i_ready && l2_ready) ? l2_rdata : '0;
        d_rdata  = (d_ready && l2_ready) ? l2_rdata : '0;
        i_wait   = i_req & ~i_ready;
        d_wait   = d_req & ~d_ready;
        dbgState = state;
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: drivers push the expected completion record
// and a negedge monitor pops and compares it on every ready pulse.
module tb_l2_arbiter;
    import l2_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int EW = 2 + AW + 3 * LW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata;
    logic          i_ready, d_ready, i_wait, d_wait;
    logic [LW-1:0] i_rdata, d_rdata;
    logic          l2_req, l2_we, l2_ready, err;
    logic [AW-1:0] l2_addr;
    logic [LW-1:0] l2_wdata, l2_rdata;
    arbStateT      dbg_state;

    int            n_vec = 0;
    int            n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] act_v, exp_v;

    int            l2_delay = 0;
    bit            l2_mute = 1'b1;
    logic [LW-1:0] l2_data = '0;
    int            req_cycles = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_ready(i_ready), .d_ready(d_ready),
        .i_rdata(i_rdata), .d_rdata(d_rdata),
        .i_wait(i_wait), .d_wait(d_wait),
        .l2_req(l2_req), .l2_we(l2_we), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_ready(l2_ready), .l2_rdata(l2_rdata),
        .err(err), .dbgState(dbg_state)
    );

    function automatic logic [EW-1:0] mk_exp(input logic side, input logic we,
                                             input logic [AW-1:0] addr,
                                             input logic [LW-1:0] wdata,
                                             input logic [LW-1:0] rdata);
        return {side, we, addr, wdata, rdata, {LW{1'b0}}};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // L2 model: l2_ready arrives l2_delay cycles after l2_req first goes high.
    initial begin
        l2_ready = 1'b0;
        l2_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            l2_ready = 1'b0;
            l2_rdata = ~l2_data;
            if (!l2_req) begin
                req_cycles = 0;
            end else begin
                req_cycles++;
                if (!l2_mute && req_cycles == l2_delay + 1) begin
                    l2_ready = 1'b1;
                    l2_rdata = l2_data;
                end
            end
        end
    end

    // Monitor: every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (i_ready || d_ready) begin
            act_v = {d_ready, l2_we, l2_addr, l2_wdata,
                     d_ready ? d_rdata : i_rdata, d_ready ? i_rdata : d_rdata};
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ready: got %0h expected no completion", act_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL completion: got %0h expected %0h", act_v, exp_v);
                end
            end
        end
    end

    task automatic i_txn(input logic [AW-1:0] addr, output int lat);
        i_req  = 1'b1;
        i_addr = addr;
        lat    = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!i_ready && lat < 200);
        if (!i_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL i_ready_wait: got no i_ready expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic d_txn(input logic we, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wdata, output int lat);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        lat     = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_ready && lat < 200);
        if (!d_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL d_ready_wait: got no d_ready expected one within 200 cycles");
        end
        @(posedge clk);
        #1;
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "bench timeout");
    end

    initial begin
        int            l1, l2, l3, l4;
        int            iw_low;
        logic [LW-1:0] wd;

        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;

        // Reset state; wait flags follow the requests even under reset.
        repeat (3) @(posedge clk);
        #1 d_req = 1'b1;
        @(negedge clk);
        chk("rst_l2_req", LW'(l2_req), LW'(0));
        chk("rst_err", LW'(err), LW'(0));
        chk("rst_state", LW'(dbg_state), LW'(IDLE));
        chk("rst_l2_addr", LW'(l2_addr), LW'(0));
        chk("rst_d_ready", LW'(d_ready), LW'(0));
        chk("rst_d_wait", LW'(d_wait), LW'(1));
        chk("rst_i_wait", LW'(i_wait), LW'(0));
        @(posedge clk);
        #1 d_req = 1'b0; rst = 1'b0;

        // Single I miss, L2 answers 3 cycles after l2_req.
        l2_mute = 1'b0; l2_delay = 3; l2_data = {16{8'hA5}};
        exp_q.push_back(mk_exp(SIDE_I, 1'b0, 32'h0000_1040, '0, {16{8'hA5}}));
        i_txn(32'h0000_1040, l1);
        chk("single_i_latency", LW'(l1), LW'(5));
        @(negedge clk);
        chk("single_i_wait_after", LW'(i_wait), LW'(0));
        chk("single_i_l2_req_after", LW'(l2_req), LW'(0));
        chk("single_i_err", LW'(err), LW'(0));

        // Simultaneous requests after reset: D wins the first tie.
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        l2_delay = 2; l2_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        wd = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
        exp_q.push_back(mk_exp(SIDE_D, 1'b1, 32'h0000_2000, wd, l2_data));
        exp_q.push_back(mk_exp(SIDE_I, 1'b0, 32'h0000_3040, '0, l2_data));
        iw_low = 0;
        fork
            i_txn(32'h0000_3040, l1);
            d_txn(1'b1, 32'h0000_2000, wd, l2);
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (!i_wait) iw_low++;
                    if (d_ready) break;
                end
            end
        join
        chk("tie_d_latency", LW'(l2), LW'(4));
        chk("tie_i_latency", LW'(l1), LW'(8));
        chk("tie_i_wait_during_d", LW'(iw_low), LW'(0));

        // Fairness: both held for four transactions, grants alternate D,I,D,I.
        l2_delay = 1; l2_data = 128'hCAFE_0000_0000_0000_0000_0000_0000_0001;
        wd = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
        exp_q.push_back(mk_exp(SIDE_D, 1'b0, 32'h0000_A000, '0, l2_data));
        exp_q.push_back(mk_exp(SIDE_I, 1'b0, 32'h0000_B040, '0, l2_data));
        exp_q.push_back(mk_exp(SIDE_D, 1'b1, 32'h0000_A100, wd, l2_data));
        exp_q.push_back(mk_exp(SIDE_I, 1'b0, 32'h0000_B080, '0, l2_data));
        fork
            begin
                i_txn(32'h0000_B040, l1);
                i_txn(32'h0000_B080, l2);
            end
            begin
                d_txn(1'b0, 32'h0000_A000, '0, l3);
                d_txn(1'b1, 32'h0000_A100, wd, l4);
            end
        join
        chk("fair_d1_latency", LW'(l3), LW'(3));
        chk("fair_i1_latency", LW'(l1), LW'(6));
        chk("fair_d2_latency", LW'(l4), LW'(6));
        chk("fair_i2_latency", LW'(l2), LW'(6));

        // Late D arrival while I owns L2.
        l2_delay = 4; l2_data = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        exp_q.push_back(mk_exp(SIDE_I, 1'b0, 32'h0000_5040, '0, l2_data));
        exp_q.push_back(mk_exp(SIDE_D, 1'b0, 32'h0000_6000, '0, l2_data));
        fork
            i_txn(32'h0000_5040, l1);
            begin
                repeat (2) @(posedge clk);
                #1 d_txn(1'b0, 32'h0000_6000, '0, l2);
            end
            begin
                repeat (5) @(negedge clk);
                chk("late_l2_addr_held", LW'(l2_addr), LW'(32'h0000_5040));
                chk("late_d_wait", LW'(d_wait), LW'(1));
            end
        join
        chk("late_i_latency", LW'(l1), LW'(6));
        chk("late_d_latency", LW'(l2), LW'(10));

        // Watchdog: silent L2 aborts the I transaction with rdata 0, err sticks.
        l2_mute = 1'b1;
        exp_q.push_back(mk_exp(SIDE_I, 1'b0, 32'h0000_7040, '0, '0));
        i_txn(32'h0000_7040, l1);
        chk("timeout_latency", LW'(l1), LW'(10));
        @(negedge clk);
        chk("timeout_err_set", LW'(err), LW'(1));
        @(posedge clk);
        #1;
        l2_mute = 1'b0; l2_delay = 0; l2_data = 128'h5A5A_5A5A_0000_1111_2222_3333_4444_5555;
        wd = 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF;
        exp_q.push_back(mk_exp(SIDE_D, 1'b1, 32'h0000_8000, wd, l2_data));
        d_txn(1'b1, 32'h0000_8000, wd, l2);
        chk("post_timeout_latency", LW'(l2), LW'(2));
        @(negedge clk);
        chk("err_sticky", LW'(err), LW'(1));

        // Reset in the second GNT_D cycle drops the transaction.
        @(posedge clk);
        #1;
        l2_mute = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000; d_wdata = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_state_before", LW'(dbg_state), LW'(GNT_D));
        chk("midrst_l2_req_before", LW'(l2_req), LW'(1));
        @(posedge clk);
        #1;
        i_req = 1'b1; i_addr = 32'h0000_9040;
        @(negedge clk);
        chk("midrst_l2_req", LW'(l2_req), LW'(0));
        chk("midrst_err", LW'(err), LW'(0));
        chk("midrst_state", LW'(dbg_state), LW'(IDLE));
        chk("midrst_d_wait", LW'(d_wait), LW'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        l2_mute = 1'b0; l2_delay = 1; l2_data = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        exp_q.push_back(mk_exp(SIDE_D, 1'b0, 32'h0000_4000, '0, l2_data));
        exp_q.push_back(mk_exp(SIDE_I, 1'b0, 32'h0000_9040, '0, l2_data));
        fork
            d_txn(1'b0, 32'h0000_4000, '0, l3);
            i_txn(32'h0000_9040, l4);
        join
        chk("midrst_d_latency", LW'(l3), LW'(3));
        chk("midrst_i_latency", LW'(l4), LW'(6));

        repeat (3) @(negedge clk);
        chk("queue_empty", LW'(exp_q.size()), LW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
